// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc: master issues operands and takes results.
// The slave side drives in_ready, the result and its flags.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op_code;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             O;
  logic             C;
  logic             Z;
  logic             N;
  logic             err;

  modport master (
    output in_valid, a, b, op_code, out_ready,
    input  in_ready, out_valid, y, O, C, Z, N, err
  );

  modport slave (
    input  in_valid, a, b, op_code, out_ready,
    output in_ready, out_valid, y, O, C, Z, N, err
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle add/sub/inc/logic, bit-serial shifts, shift-add multiply, registered flags.
// Latency 1 / s+1 (shift by s) / WIDTH+1 (mul); in_ready only in IDLE; result held until out_ready.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave bus
);
  localparam int          SW      = $clog2(WIDTH);
  localparam logic [SW:0] CNT_MUL = (SW+1)'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_INC = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_SRA = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  typedef enum logic [1:0] {IDLE, EXEC, BUSY, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             o;
    logic             c;
    logic             err;
  } res_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, y_q;
  logic [3:0]       op_q;
  logic [SW:0]      cnt;
  logic             c_q;
  logic             o_f, c_f, z_f, n_f, err_f;
  logic [WIDTH:0]   sum, mul_sum;
  logic             is_iter, finish;
  res_t             res;

  assign is_iter = (bus.op_code >= OP_SHL) && (bus.op_code <= OP_MUL);
  assign finish  = (state == EXEC) || ((state == BUSY) && (cnt == '0));
  // One multiplier bit per cycle: conditionally add a into the high half, then shift the pair right.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.y         = y_q;
  assign bus.O         = o_f;
  assign bus.C         = c_f;
  assign bus.Z         = z_f;
  assign bus.N         = n_f;
  assign bus.err       = err_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.in_valid) next_state = is_iter ? BUSY : EXEC;
      EXEC: next_state = DONE;
      BUSY: if (cnt == '0) next_state = DONE;
      DONE: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    res = '0;
    sum = '0;
    if (state == BUSY) begin
      res.y = lo_q;
      if (op_q == OP_MUL) begin
        res.c = |hi_q;
        res.o = |hi_q;
      end else begin
        res.c = c_q;
      end
    end else begin
      case (op_q)
        OP_ADD: begin
          sum   = {1'b0, a_q} + {1'b0, b_q};
          res.y = sum[WIDTH-1:0];
          res.c = sum[WIDTH];
          res.o = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res.y[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          res.y = a_q - b_q;
          res.c = a_q < b_q;
          res.o = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res.y[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_INC: begin
          sum   = {1'b0, a_q} + (WIDTH+1)'(1);
          res.y = sum[WIDTH-1:0];
          res.c = sum[WIDTH];
          res.o = !a_q[WIDTH-1] && res.y[WIDTH-1];
        end
        OP_AND:  res.y = a_q & b_q;
        OP_OR:   res.y = a_q | b_q;
        OP_XOR:  res.y = a_q ^ b_q;
        OP_NOT:  res.y = ~a_q;
        default: res.err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= '0;
      cnt   <= '0;
      c_q   <= 1'b0;
      y_q   <= '0;
      o_f   <= 1'b0;
      c_f   <= 1'b0;
      z_f   <= 1'b0;
      n_f   <= 1'b0;
      err_f <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.in_valid) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.op_code;
        hi_q <= '0;
        c_q  <= 1'b0;
        lo_q <= (bus.op_code == OP_MUL) ? bus.b : bus.a;
        cnt  <= (bus.op_code == OP_MUL) ? CNT_MUL : {1'b0, bus.b[SW-1:0]};
      end
      if (finish) begin
        y_q   <= res.y;
        o_f   <= res.o;
        c_f   <= res.c;
        z_f   <= (res.y == '0);
        n_f   <= res.y[WIDTH-1];
        err_f <= res.err;
      end else if (state == BUSY) begin
        cnt <= cnt - (SW+1)'(1);
        case (op_q)
          OP_SHL: begin
            c_q  <= lo_q[WIDTH-1];
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
          OP_SHR: begin
            c_q  <= lo_q[0];
            lo_q <= {1'b0, lo_q[WIDTH-1:1]};
          end
          OP_SRA: begin
            c_q  <= lo_q[0];
            lo_q <= {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
          end
          OP_MUL: begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flags packed as {O, C, Z, N, err}.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] y, output logic [4:0] fl, output int lat);
    longint    sa, sb, r;
    int        s;
    logic [63:0] p;
    logic      c, o, e;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    s   = int'(b[4:0]);
    c   = 1'b0;
    o   = 1'b0;
    e   = 1'b0;
    lat = 1;
    y   = '0;
    case (op)
      4'h0: begin
        p = 64'(a) + 64'(b); y = p[W-1:0]; c = p[W];
        r = sa + sb; o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'h1: begin
        y = a - b; c = (a < b);
        r = sa - sb; o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'h2: begin y = a + 1; c = (a == 32'hFFFF_FFFF); o = (a == 32'h7FFF_FFFF); end
      4'h3: y = a & b;
      4'h4: y = a | b;
      4'h5: y = a ^ b;
      4'h6: y = ~a;
      4'h7: begin y = a << s; c = (s == 0) ? 1'b0 : a[W-s]; lat = s + 1; end
      4'h8: begin y = a >> s; c = (s == 0) ? 1'b0 : a[s-1]; lat = s + 1; end
      4'h9: begin y = $signed(a) >>> s; c = (s == 0) ? 1'b0 : a[s-1]; lat = s + 1; end
      4'hA: begin p = 64'(a) * 64'(b); y = p[W-1:0]; c = |p[63:32]; o = c; lat = W + 1; end
      default: e = 1'b1;
    endcase
    fl = {o, c, (y == '0), y[W-1], e};
  endfunction

  // Issues one op from IDLE and returns once out_valid is seen; the result is left unconsumed.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] yo, output logic [4:0] flo, output bit tmo);
    int n;
    tmo = 1'b0;
    bus.op_code  = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) tmo = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_code  = 4'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 100) tmo = 1'b1;
    yo  = bus.y;
    flo = {bus.O, bus.C, bus.Z, bus.N, bus.err};
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+6:0] got;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op_code = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    got = {bus.in_ready, bus.out_valid, bus.y, bus.O, bus.C, bus.Z, bus.N, bus.err};
    checks++;
    if (got !== {1'b1, 1'b0, {W{1'b0}}, 5'b0}) begin
      errors++; $display("FAIL reset_state got=%h want=%h", got, {1'b1, 1'b0, {W{1'b0}}, 5'b0});
    end
  endtask

  task automatic test_directed();
    logic [3:0]   ops [13] = '{4'h0, 4'h1, 4'h1, 4'h9, 4'h7, 4'hA, 4'hA, 4'h2, 4'h2, 4'h6, 4'hF, 4'h8, 4'h7};
    logic [W-1:0] as  [13] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h8000_0001, 32'h1234_5678,
                               32'h0001_0000, 32'h7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h5,
                               32'h3, 32'h8000_0000};
    logic [W-1:0] bs  [13] = '{32'h1, 32'h1, 32'h2, 32'h4, 32'h0, 32'h0001_0000, 32'h6, 32'h0, 32'h0,
                               32'h0, 32'h9, 32'h1, 32'hFFFF_FFE1};
    logic [W-1:0] ys  [13] = '{32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hF800_0000, 32'h1234_5678,
                               32'h0, 32'd42, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0};
    logic [4:0]   fs  [13] = '{5'b01100, 5'b10000, 5'b01010, 5'b00010, 5'b00000, 5'b11100, 5'b00000,
                               5'b10010, 5'b01100, 5'b00010, 5'b00101, 5'b01000, 5'b01100};
    int           ls  [13] = '{1, 1, 1, 5, 1, 33, 33, 1, 1, 1, 1, 2, 2};
    int lat; logic [W-1:0] y; logic [4:0] fl; bit tmo;
    for (int i = 0; i < 13; i++) begin
      run_op(ops[i], as[i], bs[i], lat, y, fl, tmo);
      checks++;
      if (tmo || lat != ls[i]) begin
        errors++; $display("FAIL dir_latency[%0d] got=%0d want=%0d tmo=%0d", i, lat, ls[i], tmo);
      end
      checks++;
      if ({y, fl} !== {ys[i], fs[i]}) begin
        errors++; $display("FAIL dir_result[%0d] got y=%h fl=%b want y=%h fl=%b", i, y, fl, ys[i], fs[i]);
      end
      consume();
    end
  endtask

  task automatic test_random();
    int lat, elat; logic [W-1:0] y, ey, a, b; logic [4:0] fl, efl; logic [3:0] op; bit tmo;
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: a = '0;
        1: a = '1;
        2: a = 32'h7FFF_FFFF;
        3: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'(1) : $urandom;
      model(op, a, b, ey, efl, elat);
      run_op(op, a, b, lat, y, fl, tmo);
      checks++;
      if (tmo || lat != elat) begin
        errors++; $display("FAIL rnd_latency op=%h got=%0d want=%0d tmo=%0d", op, lat, elat, tmo);
      end
      checks++;
      if ({y, fl} !== {ey, efl}) begin
        errors++; $display("FAIL rnd_result op=%h a=%h b=%h got y=%h fl=%b want y=%h fl=%b",
                           op, a, b, y, fl, ey, efl);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] y; logic [4:0] fl; bit tmo;
    run_op(4'hA, 32'd7, 32'd6, lat, y, fl, tmo);
    bus.in_valid = 1'b1; bus.op_code = 4'h0; bus.a = 32'd1; bus.b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
        errors++; $display("FAIL bp_handshake cyc=%0d got=%b want=10", i, {bus.out_valid, bus.in_ready});
      end
      checks++;
      if ({bus.y, bus.O, bus.C, bus.Z, bus.N, bus.err} !== {32'd42, 5'b00000}) begin
        errors++; $display("FAIL bp_hold cyc=%0d got y=%h want y=%h", i, bus.y, 32'd42);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.y} !== {2'b10, 32'd42}) begin
      errors++; $display("FAIL bp_release got rdy/vld=%b y=%h want 10 y=%h",
                         {bus.in_ready, bus.out_valid}, bus.y, 32'd42);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.op_code = 4'h0; bus.a = 32'd3; bus.b = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_code = 4'h1; bus.a = 32'd20; bus.b = 32'd3;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.y} !== {2'b10, 32'd7}) begin
      errors++; $display("FAIL b2b_first got vld/rdy=%b y=%h want 10 y=%h",
                         {bus.out_valid, bus.in_ready}, bus.y, 32'd7);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++; $display("FAIL b2b_handoff got vld/rdy=%b want 01", {bus.out_valid, bus.in_ready});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      errors++; $display("FAIL b2b_accept got vld/rdy=%b want 00", {bus.out_valid, bus.in_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.y, bus.O, bus.C, bus.Z, bus.N, bus.err} !== {1'b1, 32'd17, 5'b00000}) begin
      errors++; $display("FAIL b2b_second got vld=%b y=%h want vld=1 y=%h", bus.out_valid, bus.y, 32'd17);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int lat, seen; logic [W-1:0] y; logic [4:0] fl; bit tmo;
    run_op(4'h0, 32'd5, 32'd5, lat, y, fl, tmo);
    consume();
    bus.op_code = 4'hA; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.y, bus.O, bus.C, bus.Z, bus.N, bus.err} !==
        {1'b1, 1'b0, {W{1'b0}}, 5'b0}) begin
      errors++; $display("FAIL rst_mid_mul got rdy=%b vld=%b y=%h", bus.in_ready, bus.out_valid, bus.y);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (seen != 0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_abort got valid_cycles=%0d rdy=%b want 0 and 1", seen, bus.in_ready);
    end
    run_op(4'hC, 32'd123, 32'd456, lat, y, fl, tmo);
    checks++;
    if (tmo || {y, fl} !== {{W{1'b0}}, 5'b00101} || lat != 1) begin
      errors++; $display("FAIL rst_illegal got y=%h fl=%b lat=%0d want y=0 fl=00101 lat=1", y, fl, lat);
    end
    consume();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
